// File: rtl/ring_meter_pkg.sv
// Shared types and default sizing for the ring oscillator period meter.
package ring_meter_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT
  } meter_state_t;

  localparam int DEF_WINDOW      = 1024;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_SETTLE      = 4;
endpackage

// File: rtl/ring_period_meter_tap_sync.sv
// Synchronizes the asynchronous ring tap and flags rising edges.
module tap_sync
  import ring_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ring_tap,
  output logic rise_pulse
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ring_tap};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/ring_period_meter.sv
// Counts synchronized ring-tap rising edges over a fixed clock window.
module ring_period_meter
  import ring_meter_pkg::*;
#(
  parameter int WINDOW      = DEF_WINDOW,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int SETTLE      = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ring_tap,
  input  logic             start,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf,
  output logic             res_stall
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int ST_W  = $clog2(SETTLE);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  meter_state_t     state_q, state_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_stall_q, res_stall_d;
  logic             rise;

  tap_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ring_tap  (ring_tap),
    .rise_pulse(rise)
  );

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    win_d       = win_q;
    edge_d      = edge_q;
    ovf_d       = ovf_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    res_stall_d = res_stall_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ring_meter_pkg::SETTLE;
          settle_d = '0;
        end
      end
      ring_meter_pkg::SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == ST_LAST) begin
          state_d = MEASURE;
          edge_d  = '0;
          ovf_d   = 1'b0;
          win_d   = '0;
        end
      end
      MEASURE: begin
        win_d = win_q + 1'b1;
        if (rise) begin
          if (edge_q == CNT_MAX) ovf_d = 1'b1;
          else edge_d = edge_q + 1'b1;
        end
        // Last window cycle's edge is folded into the reported result
        if (win_q == WIN_LAST) begin
          state_d     = REPORT;
          res_count_d = edge_d;
          res_ovf_d   = ovf_d;
          res_stall_d = (edge_d == '0);
        end
      end
      REPORT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      win_q       <= '0;
      edge_q      <= '0;
      ovf_q       <= 1'b0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
      res_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      win_q       <= win_d;
      edge_q      <= edge_d;
      ovf_q       <= ovf_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
      res_stall_q <= res_stall_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == REPORT);
  assign res_count = res_count_q;
  assign res_ovf   = res_ovf_q;
  assign res_stall = res_stall_q;
endmodule

// File: tb/tb_ring_period_meter.sv
// Directed vector bench for ring_period_meter, WINDOW=16 and SETTLE=4.
module tb_ring_period_meter;
  localparam int WIN = 16;
  localparam int STL = 4;
  localparam int LAT = STL + WIN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ring_tap = 1'b0;
  logic        start = 1'b0;
  logic        res_ready = 1'b0;
  logic        busy, res_valid, res_ovf, res_stall;
  logic [15:0] res_count;
  logic        busy2, res_valid2, res_ovf2, res_stall2;
  logic [1:0]  res_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ring_period_meter #(
    .WINDOW(WIN), .CNT_W(16), .SYNC_STAGES(2), .SETTLE(STL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ring_tap(ring_tap), .start(start),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_ovf(res_ovf), .res_stall(res_stall)
  );

  ring_period_meter #(
    .WINDOW(WIN), .CNT_W(2), .SYNC_STAGES(2), .SETTLE(STL)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ring_tap(ring_tap), .start(start),
    .busy(busy2), .res_valid(res_valid2), .res_ready(res_ready),
    .res_count(res_count2), .res_ovf(res_ovf2), .res_stall(res_stall2)
  );

  typedef struct {
    int mode;
    bit use2;
    int cnt;
    bit ovf;
    bit stall;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 0: low, 1: high, 2: period 4, 3: period 2, 4: one pulse in SETTLE
  function automatic logic tap_val(int mode, int n);
    case (mode)
      1: return 1'b1;
      2: return n[1];
      3: return n[0];
      4: return (n == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_meas(int mode, output int lat);
    int n;
    ring_tap = (mode == 1);
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    ring_tap = tap_val(mode, n);
    while (!res_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      ring_tap = tap_val(mode, n);
    end
    lat = n;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk("valid_after_ack", res_valid, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{mode: 2, use2: 0, cnt: 4, ovf: 0, stall: 0};
    vecs[1] = '{mode: 0, use2: 0, cnt: 0, ovf: 0, stall: 1};
    vecs[2] = '{mode: 1, use2: 0, cnt: 0, ovf: 0, stall: 1};
    vecs[3] = '{mode: 3, use2: 1, cnt: 3, ovf: 1, stall: 0};
    vecs[4] = '{mode: 3, use2: 0, cnt: 8, ovf: 0, stall: 0};
    vecs[5] = '{mode: 4, use2: 0, cnt: 0, ovf: 0, stall: 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", res_count, 0);
    chk("rst_ovf", res_ovf, 0);
    chk("rst_stall", res_stall, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_meas(vecs[i].mode, lat);
      chk($sformatf("v%0d_latency", i), lat, LAT);
      if (vecs[i].use2) begin
        chk($sformatf("v%0d_count", i), res_count2, vecs[i].cnt);
        chk($sformatf("v%0d_ovf", i), res_ovf2, vecs[i].ovf);
        chk($sformatf("v%0d_stall", i), res_stall2, vecs[i].stall);
      end else begin
        chk($sformatf("v%0d_count", i), res_count, vecs[i].cnt);
        chk($sformatf("v%0d_ovf", i), res_ovf, vecs[i].ovf);
        chk($sformatf("v%0d_stall", i), res_stall, vecs[i].stall);
      end
      ack();
    end

    // Back-pressure in REPORT with a start pulse that must be ignored
    do_meas(2, lat);
    chk("bp_latency", lat, LAT);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      @(posedge clk);
      #1;
      chk("bp_valid_hold", res_valid, 1);
      chk("bp_count_hold", res_count, 4);
    end
    start = 1'b0;
    ack();
    chk("bp_count_kept", res_count, 4);
    @(posedge clk);
    #1;
    chk("bp_no_queued_start", busy, 0);

    // Reset in the middle of MEASURE, then a fresh measurement
    ring_tap = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < STL + 6; n++) begin
      ring_tap = tap_val(2, n);
      @(posedge clk);
      #1;
    end
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", res_valid, 0);
    chk("mrst_count", res_count, 0);
    do_meas(2, lat);
    chk("mrst_re_latency", lat, LAT);
    chk("mrst_re_count", res_count, 4);
    chk("mrst_re_stall", res_stall, 0);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
